apb_master_bridge: RTL and testbench

- Single-outstanding APB initiator that turns a simple valid/ready request port into APB setup and access phases.
- Drives the same APB signal set that our peripheral register interfaces respond to: apb_psel, apb_rw, apb_addr, apb_enab, data, apb_ack.
- Sits between the CPU/DMA-side interconnect and the APB peripheral segment, and returns read data or a timeout error as a one-cycle response pulse.

---
 rtl/apb_master_bridge_pkg.sv | 25 ++
 rtl/apb_master_bridge.sv | 148 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_pkg.sv
// ---------------------------------------------------------------------------
// apb_master_bridge_pkg : shared widths and helpers for the APB master bridge
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_master_bridge_pkg;

  localparam int unsigned c_DEFAULT_TIMEOUT = 16;

  // A disabled timeout (0) still needs a 1-bit counter so the port list stays legal.
  function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge : single-outstanding valid/ready to APB initiator
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT,
  parameter int unsigned ADDR_W         = `ADDR_WIDTH,
  parameter int unsigned DATA_W         = `APB_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              apb_psel,
  output logic              apb_rw,
  output logic [ADDR_W-1:0] apb_addr,
  output logic              apb_enab,
  output logic [DATA_W-1:0] apb_datao,
  input  logic [DATA_W-1:0] apb_datai,
  input  logic              apb_ack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  localparam int unsigned c_CNT_W  = cnt_width(TIMEOUT_CYCLES);
  localparam bit          c_TO_EN  = (TIMEOUT_CYCLES > 0);
  localparam int unsigned c_LAST_I = c_TO_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [c_CNT_W-1:0] c_LAST = c_LAST_I[c_CNT_W-1:0];

  state_t              state_q, state_d;
  logic                psel_q, psel_d;
  logic                enab_q, enab_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [c_CNT_W-1:0]  cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      enab_q      <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      enab_q      <= enab_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    enab_d      = enab_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rw_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          psel_d  = 1'b1;
          enab_d  = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        enab_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // Ack is checked first so it wins over a timeout on the same cycle.
        if (apb_ack) begin
          rsp_valid_d = 1'b1;
          rdata_d     = rw_q ? '0 : apb_datai;
          err_d       = 1'b0;
          psel_d      = 1'b0;
          enab_d      = 1'b0;
          state_d     = S_IDLE;
        end else if (c_TO_EN && (cnt_q == c_LAST)) begin
          rsp_valid_d = 1'b1;
          rdata_d     = '0;
          err_d       = 1'b1;
          psel_d      = 1'b0;
          enab_d      = 1'b0;
          state_d     = S_IDLE;
        end else if (c_TO_EN) begin
          cnt_d = cnt_q + {{(c_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        psel_d  = 1'b0;
        enab_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign apb_psel  = psel_q;
  assign apb_enab  = enab_q;
  assign apb_rw    = rw_q;
  assign apb_addr  = addr_q;
  assign apb_datao = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge : directed scoreboard bench for apb_master_bridge
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MODE_AUTO   = 0;
  localparam int MODE_MANUAL = 1;
  localparam int MODE_SILENT = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          apb_psel, apb_rw, apb_enab, apb_ack;
  logic [AW-1:0] apb_addr;
  logic [DW-1:0] apb_datao, apb_datai;

  int            tests = 0;
  int            fails = 0;
  int            mode  = MODE_AUTO;
  logic          manual_ack = 1'b0;
  longint        cyc = 0;

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
  } rsp_t;
  rsp_t exp_q[$];

  logic [DW-1:0] regs [8];

  always #5 clk = ~clk;

  apb_master_bridge #(.TIMEOUT_CYCLES(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb_psel  (apb_psel),
    .apb_rw    (apb_rw),
    .apb_addr  (apb_addr),
    .apb_enab  (apb_enab),
    .apb_datao (apb_datao),
    .apb_datai (apb_datai),
    .apb_ack   (apb_ack)
  );

  // Register-interface responder: auto mode acks in the first ACCESS cycle.
  assign apb_ack   = (mode == MODE_AUTO)   ? (apb_psel & apb_enab) :
                     (mode == MODE_MANUAL) ? manual_ack : 1'b0;
  assign apb_datai = regs[apb_addr[4:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (apb_psel && apb_enab && apb_ack && apb_rw)
      regs[apb_addr[4:2]] <= apb_datao;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  rsp_t mon_e;
  always @(negedge clk) begin
    if (resetn === 1'b1 && rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL rsp_unexpected: observed rsp_valid=1 err=%0b rdata=0x%0h expected no response",
               rsp_err, rsp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_err", {63'd0, rsp_err}, {63'd0, mon_e.err});
        check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, mon_e.rdata});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic txn(input string tag, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [DW-1:0] er);
    drive(w, a, d);
    exp_q.push_back(rsp_t'{1'b0, er});
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
  endtask

  longint acc [4];
  logic   accepted;
  int     enab_cycles;
  logic   done;
  logic [AW-1:0] b2b_addr [4];
  logic [DW-1:0] b2b_data [4];
  logic [DW-1:0] b2b_exp  [4];
  logic          b2b_w    [4];

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_psel",   {63'd0, apb_psel},  64'd0);
    check("rst_enab",   {63'd0, apb_enab},  64'd0);
    check("rst_rw",     {63'd0, apb_rw},    64'd0);
    check("rst_rsp_v",  {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_e",  {63'd0, rsp_err},   64'd0);
    check("rst_addr",   {32'd0, apb_addr},  64'd0);
    check("rst_datao",  {32'd0, apb_datao}, 64'd0);
    check("rst_rdata",  {32'd0, rsp_rdata}, 64'd0);
    check("rst_ready",  {63'd0, req_ready}, 64'd1);
    resetn = 1'b1;

    // Write with per-phase timing checks
    drive(1'b1, 32'h08, 32'hDEADBEEF);
    exp_q.push_back(rsp_t'{1'b0, 32'd0});
    tick();
    req_valid = 1'b0;
    check("wr_setup_psel", {63'd0, apb_psel},  64'd1);
    check("wr_setup_enab", {63'd0, apb_enab},  64'd0);
    check("wr_setup_addr", {32'd0, apb_addr},  64'h08);
    check("wr_setup_rw",   {63'd0, apb_rw},    64'd1);
    check("wr_setup_data", {32'd0, apb_datao}, 64'hDEADBEEF);
    check("wr_setup_rdy",  {63'd0, req_ready}, 64'd0);
    tick();
    check("wr_acc_psel", {63'd0, apb_psel}, 64'd1);
    check("wr_acc_enab", {63'd0, apb_enab}, 64'd1);
    tick();
    check("wr_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("wr_rsp_ready", {63'd0, req_ready}, 64'd1);
    check("wr_reg2",      {32'd0, regs[2]},   64'hDEADBEEF);

    txn("wr5", 1'b1, 32'h14, 32'h12345678, 32'd0);
    txn("rd5", 1'b0, 32'h14, 32'd0, 32'h12345678);

    // Back-to-back with req_valid held high
    b2b_w[0] = 1'b1; b2b_addr[0] = 32'h00; b2b_data[0] = 32'hA5A5A5A5; b2b_exp[0] = 32'd0;
    b2b_w[1] = 1'b0; b2b_addr[1] = 32'h14; b2b_data[1] = 32'd0;        b2b_exp[1] = 32'h12345678;
    b2b_w[2] = 1'b1; b2b_addr[2] = 32'h0C; b2b_data[2] = 32'h0F0F0F0F; b2b_exp[2] = 32'd0;
    b2b_w[3] = 1'b0; b2b_addr[3] = 32'h08; b2b_data[3] = 32'd0;        b2b_exp[3] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      drive(b2b_w[i], b2b_addr[i], b2b_data[i]);
      exp_q.push_back(rsp_t'{1'b0, b2b_exp[i]});
      accepted = 1'b0;
      for (int k = 0; k < 8 && !accepted; k++) begin
        @(negedge clk);
        if (req_ready === 1'b1) accepted = 1'b1;
        @(posedge clk);
        acc[i] = cyc;
      end
      #1;
      check("b2b_accepted", {63'd0, accepted}, 64'd1);
      if (i > 0) check("b2b_spacing", 64'(acc[i] - acc[i-1]), 64'd3);
    end
    req_valid = 1'b0;
    tick();
    tick();
    check("b2b_last_rsp", {63'd0, rsp_valid}, 64'd1);
    tick();
    check("b2b_drained", 64'(exp_q.size()), 64'd0);
    txn("rd0", 1'b0, 32'h00, 32'd0, 32'hA5A5A5A5);

    // Timeout: responder never acks
    mode = MODE_SILENT;
    drive(1'b0, 32'h08, 32'd0);
    exp_q.push_back(rsp_t'{1'b1, 32'd0});
    tick();
    req_valid = 1'b0;
    enab_cycles = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) done = 1'b1;
      else if (apb_enab === 1'b1) enab_cycles++;
    end
    check("to_seen",        {63'd0, done},  64'd1);
    check("to_enab_cycles", 64'(enab_cycles), 64'd4);
    tick();

    // Spurious ack in SETUP, real ack on third ACCESS cycle
    mode = MODE_MANUAL;
    manual_ack = 1'b0;
    drive(1'b0, 32'h14, 32'd0);
    exp_q.push_back(rsp_t'{1'b0, 32'h12345678});
    tick();
    req_valid = 1'b0;
    manual_ack = 1'b1;
    tick();
    manual_ack = 1'b0;
    check("late_acc1_enab",  {63'd0, apb_enab},  64'd1);
    check("late_acc1_rspv",  {63'd0, rsp_valid}, 64'd0);
    tick();
    check("late_acc2_enab",  {63'd0, apb_enab},  64'd1);
    tick();
    manual_ack = 1'b1;
    tick();
    manual_ack = 1'b0;
    check("late_rsp_valid",  {63'd0, rsp_valid}, 64'd1);
    check("late_psel_drop",  {63'd0, apb_psel},  64'd0);

    // Ack on the final timeout cycle wins
    drive(1'b0, 32'h14, 32'd0);
    exp_q.push_back(rsp_t'{1'b0, 32'h12345678});
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    check("edge_acc3_enab", {63'd0, apb_enab}, 64'd1);
    tick();
    manual_ack = 1'b1;
    tick();
    manual_ack = 1'b0;
    check("edge_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("edge_rsp_err",   {63'd0, rsp_err},   64'd0);

    // Reset in the middle of ACCESS aborts silently
    drive(1'b1, 32'h10, 32'h11111111);
    tick();
    req_valid = 1'b0;
    tick();
    check("rst_mid_enab_pre", {63'd0, apb_enab}, 64'd1);
    resetn = 1'b0;
    tick();
    check("rst_mid_psel",  {63'd0, apb_psel},  64'd0);
    check("rst_mid_enab",  {63'd0, apb_enab},  64'd0);
    check("rst_mid_rspv",  {63'd0, rsp_valid}, 64'd0);
    resetn = 1'b1;
    check("rst_mid_ready", {63'd0, req_ready}, 64'd1);
    mode = MODE_AUTO;
    txn("post_rst_rd", 1'b0, 32'h14, 32'd0, 32'h12345678);
    tick();
    tick();
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed no completion, expected finish before 50000");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
